// File: rtl/counter_updown_param.sv
// Parametrised synchronous up/down counter with load clamp, wrap/saturate end behaviour,
// combinational cascade terminal count and a registered boundary event flag.
module counter_updown_param #(
    parameter int unsigned     WIDTH    = 6,
    parameter longint unsigned MODULUS  = 64,
    parameter bit              SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max_s;
    logic             at_zero_s;
    logic             at_bound_s;

    // Loaded values beyond the count range pin to the top of the range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        if (val > MAX_VAL) begin
            return MAX_VAL;
        end else begin
            return val;
        end
    endfunction

    // Boundary detection and cascade terminal count.
    always_comb begin
        at_max_s   = (count_q == MAX_VAL);
        at_zero_s  = (count_q == ZERO_VAL);
        at_bound_s = up ? at_max_s : at_zero_s;
        tc         = en & at_bound_s;
    end

    // Next count and boundary event: load beats count.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = clamp_load(load_val);
            wrap_d  = 1'b0;
        end else if (en) begin
            wrap_d = at_bound_s;
            if (up) begin
                if (at_max_s) begin
                    count_d = SAT_MODE ? MAX_VAL : ZERO_VAL;
                end else begin
                    count_d = count_q + ONE_VAL;
                end
            end else begin
                if (at_zero_s) begin
                    count_d = SAT_MODE ? ZERO_VAL : MAX_VAL;
                end else begin
                    count_d = count_q - ONE_VAL;
                end
            end
        end else begin
            count_d = count_q;
            wrap_d  = 1'b0;
        end
    end

    // Count and event registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ZERO_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_updown_param.sv
// Self-checking bench for counter_updown_param: hand-derived vector table, directed
// corner sequences, a two-stage cascade and random stimulus against an arithmetic model.
module tb_counter_updown_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, load;
    logic [5:0] lv;
    logic [5:0] q_def;
    logic       tc_def, wrap_def;
    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, wrap_w, wrap_s;
    logic       c_rst, c_en;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, wrap_lo, wrap_hi;

    int n_cmp = 0;
    int n_bad = 0;

    counter_updown_param #(.WIDTH(6), .MODULUS(64), .SAT_MODE(1'b0)) u_def (
        .clk(clk), .reset(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .q(q_def), .tc(tc_def), .wrap(wrap_def));
    counter_updown_param #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1'b0)) u_w10 (
        .clk(clk), .reset(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .q(q_w), .tc(tc_w), .wrap(wrap_w));
    counter_updown_param #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1'b1)) u_s10 (
        .clk(clk), .reset(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .q(q_s), .tc(tc_s), .wrap(wrap_s));
    counter_updown_param #(.WIDTH(4), .MODULUS(16), .SAT_MODE(1'b0)) u_lo (
        .clk(clk), .reset(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .q(q_lo), .tc(tc_lo), .wrap(wrap_lo));
    counter_updown_param #(.WIDTH(4), .MODULUS(16), .SAT_MODE(1'b0)) u_hi (
        .clk(clk), .reset(c_rst), .en(tc_lo), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .q(q_hi), .tc(tc_hi), .wrap(wrap_hi));

    // Reference model state for u_def, u_w10, u_s10
    int mod_c[3] = '{64, 10, 10};
    bit sat_c[3] = '{1'b0, 1'b0, 1'b1};
    int mq[3]    = '{0, 0, 0};
    int mw[3]    = '{0, 0, 0};

    typedef struct {
        bit         r, e, u, ld;
        logic [5:0] v;
        int         qw, ww, qs, ws;
    } vec_t;
    vec_t tv[15];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_tc(input int i);
        if (!en) return 0;
        return up ? int'(mq[i] == mod_c[i] - 1) : int'(mq[i] == 0);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int lvi;
            int raw;
            lvi = (i == 0) ? int'(lv) : int'(lv[3:0]);
            mw[i] = 0;
            if (rst) begin
                mq[i] = 0;
            end else if (load) begin
                mq[i] = (lvi > mod_c[i] - 1) ? mod_c[i] - 1 : lvi;
            end else if (en) begin
                raw = up ? mq[i] + 1 : mq[i] - 1;
                if (raw < 0 || raw >= mod_c[i]) begin
                    mw[i] = 1;
                    mq[i] = sat_c[i] ? mq[i] : (raw + mod_c[i]) % mod_c[i];
                end else begin
                    mq[i] = raw;
                end
            end
        end
    endtask

    task automatic apply(input bit r, input bit e, input bit u, input bit ld, input logic [5:0] v);
        rst = r; en = e; up = u; load = ld; lv = v;
        #1;
        if (!r) begin
            check("tc_def", int'(tc_def), model_tc(0));
            check("tc_w10", int'(tc_w), model_tc(1));
            check("tc_s10", int'(tc_s), model_tc(2));
        end
        model_step();
        @(posedge clk);
        #1;
        check("q_def", int'(q_def), mq[0]);
        check("wrap_def", int'(wrap_def), mw[0]);
        check("q_w10", int'(q_w), mq[1]);
        check("wrap_w10", int'(wrap_w), mw[1]);
        check("q_s10", int'(q_s), mq[2]);
        check("wrap_s10", int'(wrap_s), mw[2]);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = 6'd0;
        c_rst = 1'b1; c_en = 1'b0;

        //        r     e     u     ld    v       qw ww qs ws
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  0, 0, 0, 0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  9, 1, 0, 1};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  8, 0, 0, 1};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  8, 0, 0, 0};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  9, 0, 1, 0};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  0, 1, 2, 0};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd5,  5, 0, 5, 0};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd13, 9, 0, 9, 0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  0, 1, 9, 1};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  1, 0, 9, 1};
        tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  0, 0, 8, 0};
        tv[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd20, 0, 0, 0, 0};
        tv[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  1, 0, 1, 0};
        tv[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd9,  9, 0, 9, 0};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 9, 0, 9, 0};

        for (int i = 0; i < 15; i++) begin
            apply(tv[i].r, tv[i].e, tv[i].u, tv[i].ld, tv[i].v);
            check($sformatf("tbl%0d_q_w10", i), int'(q_w), tv[i].qw);
            check($sformatf("tbl%0d_wrap_w10", i), int'(wrap_w), tv[i].ww);
            check($sformatf("tbl%0d_q_s10", i), int'(q_s), tv[i].qs);
            check($sformatf("tbl%0d_wrap_s10", i), int'(wrap_s), tv[i].ws);
        end

        // Full-range up count on the default instance
        apply(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        for (int k = 1; k <= 64; k++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
            check("seq64_q", int'(q_def), k % 64);
            check("seq64_wrap", int'(wrap_def), int'(k == 64));
            check("seq64_tc", int'(tc_def), int'(k % 64 == 63));
        end

        // Modulus-10 down count from reset
        apply(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int k = 1; k <= 20; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
            check("down10_q", int'(q_w), (10 - (k % 10)) % 10);
            check("down10_wrap", int'(wrap_w), int'(k % 10 == 1));
            check("down10_tc", int'(tc_w), int'(k % 10 == 0));
        end

        // Saturate at the top, then reverse
        apply(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        for (int k = 1; k <= 12; k++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
            check("sat_q", int'(q_s), (k < 9) ? k : 9);
            check("sat_wrap", int'(wrap_s), int'(k >= 10));
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("sat_rev_q", int'(q_s), 8);
        check("sat_rev_wrap", int'(wrap_s), 0);

        // Reset mid-count overrides a simultaneous load
        apply(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        for (int k = 0; k < 37; k++) apply(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        check("mid_q37", int'(q_def), 37);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 6'd20);
        check("mid_rst_q", int'(q_def), 0);
        check("mid_rst_wrap", int'(wrap_def), 0);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        check("mid_resume1", int'(q_def), 1);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
        check("mid_resume2", int'(q_def), 2);

        // Random stimulus against the model
        apply(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
        for (int k = 0; k < 400; k++) begin
            apply(($urandom % 50) == 0, ($urandom % 4) != 0, $urandom_range(0, 1) == 1,
                  ($urandom % 8) == 0, 6'($urandom % 64));
        end

        // Two-stage cascade, 8-bit combined count
        @(posedge clk); #1;
        c_rst = 1'b0; c_en = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk); #1;
            check("casc_q", int'({q_hi, q_lo}), k % 256);
            check("casc_wrap_lo", int'(wrap_lo), int'(k % 16 == 0));
            check("casc_wrap_hi", int'(wrap_hi), int'(k == 256));
            if (k == 255) begin
                check("casc_tc_lo", int'(tc_lo), 1);
                check("casc_tc_hi", int'(tc_hi), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
